multicycle_sequencer: RTL and testbench

Control-state sequencer for the multi-cycle MIPS core: owns the state register that steps each instruction through IF/ID/EXEC/MEM/WB and drives the `state` input of the instruction-parse/control LUT. Consumes the latched opcode/funct from the instruction register and memory ready handshakes. Produces the fetch-stage enables, the per-instruction retire pulse and an illegal-opcode flag.

---
 rtl/multicycle_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_multicycle_sequencer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer
// Control-state sequencer for the multi-cycle MIPS core. Steps each instruction
// through IF/ID/EXEC/MEM/WB. It produces the fetch-stage enables, a retire pulse
// on the last cycle of each instruction, and a sticky illegal-instruction flag.
//
// Optional feature: define SEQ_PERF_COUNT_EN to implement the retired-instruction
// and run-cycle counters. When it is undefined, both counters read 32'd0 and no
// count registers exist.
module multicycle_sequencer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic        mem_ready,
    output logic [2:0]  state,
    output logic        fetch_req,
    output logic        ir_we,
    output logic        pc_inc_we,
    output logic        retire,
    output logic        illegal,
    output logic [31:0] instr_count,
    output logic [31:0] cycle_count
);

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EXEC = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_JR    = 6'b001000;
    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_SLT   = 6'b101010;

    state_t state_q;
    state_t next_state;
    logic   set_illegal;
    logic   illegal_q;

    logic is_lw, is_sw, is_j, is_jal, is_beq, is_bne, is_xori, is_addi;
    logic is_rtype, is_alu_r, is_jr, is_legal;
    logic fetch_raw, ir_we_raw, retire_raw;

    // Instruction class decode from the IR opcode/funct fields
    always_comb begin
        is_lw    = (opcode == OP_LW);
        is_sw    = (opcode == OP_SW);
        is_j     = (opcode == OP_J);
        is_jal   = (opcode == OP_JAL);
        is_beq   = (opcode == OP_BEQ);
        is_bne   = (opcode == OP_BNE);
        is_xori  = (opcode == OP_XORI);
        is_addi  = (opcode == OP_ADDI);
        is_rtype = (opcode == OP_RTYPE);
        is_alu_r = is_rtype && ((funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_SLT));
        is_jr    = is_rtype && (funct == FN_JR);
        is_legal = is_lw || is_sw || is_j || is_jal || is_beq || is_bne ||
                   is_xori || is_addi || is_alu_r || is_jr;
    end

    // Next-state and combinational control outputs for the current state
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned
        // (which would infer a latch); each state arm only overrides what it uses.
        next_state  = S_IF;
        fetch_raw   = 1'b0;
        ir_we_raw   = 1'b0;
        retire_raw  = 1'b0;
        set_illegal = 1'b0;
        case (state_q)
            S_IF: begin
                fetch_raw = run;
                if (run && mem_ready) begin
                    ir_we_raw  = 1'b1;
                    next_state = S_ID;
                end else begin
                    next_state = S_IF;
                end
            end
            S_ID: begin
                if (!is_legal) begin
                    set_illegal = 1'b1;
                end else if (is_j) begin
                    retire_raw = 1'b1;
                end else begin
                    next_state = S_EXEC;
                end
            end
            S_EXEC: begin
                if (is_lw || is_sw || is_jal || is_beq || is_bne) begin
                    next_state = S_MEM;
                end else if (is_alu_r || is_xori || is_addi) begin
                    next_state = S_WB;
                end else if (is_jr) begin
                    retire_raw = 1'b1;
                end
            end
            S_MEM: begin
                if (is_lw) begin
                    next_state = mem_ready ? S_WB : S_MEM;
                end else if (is_sw) begin
                    if (mem_ready) begin
                        retire_raw = 1'b1;
                    end else begin
                        next_state = S_MEM;
                    end
                end else if (is_jal) begin
                    retire_raw = 1'b1;
                end else if (is_beq || is_bne) begin
                    next_state = S_WB;
                end
            end
            S_WB: begin
                retire_raw = 1'b1;
            end
            default: begin
                // Unreachable encodings fall back to IF without side effects
                next_state = S_IF;
            end
        endcase
    end

    // Outputs are forced low while reset is held, even though state already reads IF
    always_comb begin
        fetch_req = fetch_raw  && rst_n;
        ir_we     = ir_we_raw  && rst_n;
        pc_inc_we = ir_we_raw  && rst_n;
        retire    = retire_raw && rst_n;
    end

    // State register and sticky illegal flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IF;
            illegal_q <= 1'b0;
        end else begin
            // NOTE: registered state uses non-blocking assignment so every flop
            // samples pre-edge values, independent of statement order.
            state_q <= next_state;
            if (set_illegal) begin
                illegal_q <= 1'b1;
            end
        end
    end

    assign state   = state_q;
    assign illegal = illegal_q;

`ifdef SEQ_PERF_COUNT_EN
    logic [31:0] instr_q;
    logic [31:0] cycle_q;

    // Performance counters: retired instructions and run-enabled cycles, both wrapping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q <= 32'd0;
            cycle_q <= 32'd0;
        end else begin
            if (retire) begin
                instr_q <= instr_q + 32'd1;
            end
            if (run) begin
                cycle_q <= cycle_q + 32'd1;
            end
        end
    end

    assign instr_count = instr_q;
    assign cycle_count = cycle_q;
`else
    assign instr_count = 32'd0;
    assign cycle_count = 32'd0;
`endif

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Testbench for multicycle_sequencer. Each driven cycle pushes its expected
// observation into a scoreboard queue; a monitor on the falling edge pops and
// compares against what the DUT presents. Counter expectations follow whether
// SEQ_PERF_COUNT_EN is defined.
module tb_multicycle_sequencer;

    localparam logic [5:0] RT   = 6'b000000;
    localparam logic [5:0] J    = 6'b000010;
    localparam logic [5:0] JAL  = 6'b000011;
    localparam logic [5:0] BEQ  = 6'b000100;
    localparam logic [5:0] BNE  = 6'b000101;
    localparam logic [5:0] ADDI = 6'b001000;
    localparam logic [5:0] XORI = 6'b001110;
    localparam logic [5:0] LW   = 6'b100011;
    localparam logic [5:0] SW   = 6'b101011;
    localparam logic [5:0] BAD  = 6'b111111;

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_JR  = 6'b001000;

    localparam logic [2:0] S_IF = 3'd0, S_ID = 3'd1, S_EX = 3'd2, S_MEM = 3'd3, S_WB = 3'd4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        mem_ready;
    logic [2:0]  state;
    logic        fetch_req, ir_we, pc_inc_we, retire, illegal;
    logic [31:0] instr_count, cycle_count;

    multicycle_sequencer dut (
        .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .funct(funct),
        .mem_ready(mem_ready), .state(state), .fetch_req(fetch_req), .ir_we(ir_we),
        .pc_inc_we(pc_inc_we), .retire(retire), .illegal(illegal),
        .instr_count(instr_count), .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  st;
        logic        fr;
        logic        we;
        logic        rt;
        logic        il;
        logic [31:0] ic;
        logic [31:0] cc;
    } exp_t;

    exp_t sb[$];

    int n_checks = 0;
    int n_fail   = 0;
    int we_pulses = 0;

    // Reference model state
    logic [31:0] m_instr = 32'd0;
    logic [31:0] m_cycle = 32'd0;
    logic        m_illegal = 1'b0;

    function automatic logic [31:0] cnt(input logic [31:0] v);
`ifdef SEQ_PERF_COUNT_EN
        return v;
`else
        return (v & 32'd0);
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs just after the rising edge and queue its expectation
    task automatic step(input logic rs, input logic rn, input logic [5:0] op,
                        input logic [5:0] fn, input logic mr, input logic [2:0] es,
                        input logic ef, input logic ew, input logic er);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n = rs; run = rn; opcode = op; funct = fn; mem_ready = mr;
        if (!rs) begin
            m_instr = 32'd0; m_cycle = 32'd0; m_illegal = 1'b0;
        end
        e.st = es; e.fr = ef; e.we = ew; e.rt = er; e.il = m_illegal;
        e.ic = cnt(m_instr); e.cc = cnt(m_cycle);
        sb.push_back(e);
        if (rs) begin
            m_cycle = m_cycle + {31'd0, rn};
            m_instr = m_instr + {31'd0, er};
        end
    endtask

    // Monitor: compare every presented cycle against the head of the scoreboard
    always @(negedge clk) begin
        if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            check("state",       {29'd0, state},       {29'd0, e.st});
            check("fetch_req",   {31'd0, fetch_req},   {31'd0, e.fr});
            check("ir_we",       {31'd0, ir_we},       {31'd0, e.we});
            check("pc_inc_we",   {31'd0, pc_inc_we},   {31'd0, e.we});
            check("retire",      {31'd0, retire},      {31'd0, e.rt});
            check("illegal",     {31'd0, illegal},     {31'd0, e.il});
            check("instr_count", instr_count,          e.ic);
            check("cycle_count", cycle_count,          e.cc);
            if (ir_we) we_pulses++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; run = 1'b0; opcode = 6'd0; funct = 6'd0; mem_ready = 1'b0;

        // Reset held with run/mem_ready high: all enables stay low
        step(0, 1, LW, 0, 1, S_IF, 0, 0, 0);
        step(0, 1, LW, 0, 1, S_IF, 0, 0, 0);

        // LW zero-wait: 0,1,2,3,4 with retire only in WB; IF opcode is junk and ignored
        step(1, 1, BAD, 0, 1, S_IF, 1, 1, 0);
        step(1, 1, LW,  0, 1, S_ID, 0, 0, 0);
        step(1, 1, LW,  0, 1, S_EX, 0, 0, 0);
        step(1, 1, LW,  0, 1, S_MEM, 0, 0, 0);
        step(1, 1, LW,  0, 1, S_WB, 0, 0, 1);

        // SW with three wait cycles in MEM, retire on the last MEM cycle
        step(1, 1, RT, 0, 1, S_IF, 1, 1, 0);
        step(1, 1, SW, 0, 1, S_ID, 0, 0, 0);
        step(1, 1, SW, 0, 1, S_EX, 0, 0, 0);
        step(1, 1, SW, 0, 0, S_MEM, 0, 0, 0);
        step(1, 1, SW, 0, 0, S_MEM, 0, 0, 0);
        step(1, 1, SW, 0, 0, S_MEM, 0, 0, 0);
        step(1, 1, SW, 0, 1, S_MEM, 0, 0, 1);

        // J (2 cycles), JR (3 cycles), ADD (4 cycles)
        we_pulses = 0;
        step(1, 1, RT, 0, 1, S_IF, 1, 1, 0);
        step(1, 1, J,  0, 1, S_ID, 0, 0, 1);
        step(1, 1, RT, 0, 1, S_IF, 1, 1, 0);
        step(1, 1, RT, F_JR, 1, S_ID, 0, 0, 0);
        step(1, 1, RT, F_JR, 1, S_EX, 0, 0, 1);
        step(1, 1, RT, 0, 1, S_IF, 1, 1, 0);
        step(1, 1, RT, F_ADD, 1, S_ID, 0, 0, 0);
        step(1, 1, RT, F_ADD, 1, S_EX, 0, 0, 0);
        step(1, 1, RT, F_ADD, 1, S_WB, 0, 0, 1);
        @(negedge clk); #1;
        check("ir_we_pulses_j_jr_add", we_pulses, 3);

        // Illegal opcode: ID back to IF, no retire, flag sticks across a valid ADDI
        step(1, 1, RT,  0, 1, S_IF, 1, 1, 0);
        step(1, 1, BAD, 0, 1, S_ID, 0, 0, 0);
        m_illegal = 1'b1;
        step(1, 1, RT,   0, 1, S_IF, 1, 1, 0);
        step(1, 1, ADDI, 0, 1, S_ID, 0, 0, 0);
        step(1, 1, ADDI, 0, 1, S_EX, 0, 0, 0);
        step(1, 1, ADDI, 0, 1, S_WB, 0, 0, 1);

        // JAL does not wait on mem_ready in MEM
        step(1, 1, RT,  0, 1, S_IF, 1, 1, 0);
        step(1, 1, JAL, 0, 1, S_ID, 0, 0, 0);
        step(1, 1, JAL, 0, 1, S_EX, 0, 0, 0);
        step(1, 1, JAL, 0, 0, S_MEM, 0, 0, 1);

        // Fetch stall, then BNE passes MEM without waiting and goes to WB
        step(1, 1, RT,  0, 0, S_IF, 1, 0, 0);
        step(1, 1, RT,  0, 1, S_IF, 1, 1, 0);
        step(1, 1, BNE, 0, 1, S_ID, 0, 0, 0);
        step(1, 1, BNE, 0, 1, S_EX, 0, 0, 0);
        step(1, 1, BNE, 0, 0, S_MEM, 0, 0, 0);
        step(1, 1, BNE, 0, 1, S_WB, 0, 0, 1);

        // XORI with run dropped mid-instruction: completes, then holds in IF
        step(1, 1, RT,   0, 1, S_IF, 1, 1, 0);
        step(1, 1, XORI, 0, 1, S_ID, 0, 0, 0);
        step(1, 0, XORI, 0, 1, S_EX, 0, 0, 0);
        step(1, 0, XORI, 0, 1, S_WB, 0, 0, 1);
        for (int i = 0; i < 10; i++) begin
            step(1, 0, LW, 0, 1, S_IF, 0, 0, 0);
        end

        // BEQ aborted by asynchronous reset during EXEC
        step(1, 1, RT,  0, 1, S_IF, 1, 1, 0);
        step(1, 1, BEQ, 0, 1, S_ID, 0, 0, 0);
        step(1, 1, BEQ, 0, 1, S_EX, 0, 0, 0);
        @(negedge clk); #2;
        rst_n = 1'b0;
        m_instr = 32'd0; m_cycle = 32'd0; m_illegal = 1'b0;
        #1;
        check("async_rst_state",   {29'd0, state}, 32'd0);
        check("async_rst_instr",   instr_count, 32'd0);
        check("async_rst_cycle",   cycle_count, 32'd0);
        check("async_rst_retire",  {31'd0, retire}, 32'd0);
        check("async_rst_illegal", {31'd0, illegal}, 32'd0);
        step(0, 1, BEQ, 0, 1, S_IF, 0, 0, 0);
        // Release: next fetch begins right away
        step(1, 1, RT, 0, 1, S_IF, 1, 1, 0);
        step(1, 1, LW, 0, 1, S_ID, 0, 0, 0);

        @(negedge clk); #1;
        check("scoreboard_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
